// File: rtl/serial_add_ctrl_if.sv
// Request/result bundle between a requester and
// the bit-serial adder controller.
interface serial_add_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full_adder cell stepped
// LSB first across WIDTH-bit operands.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH)
) (
  input logic          clk,
  input logic          rst,
  serial_add_ctrl_if.slave bus
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_sha;
  logic [WIDTH-1:0] r_shb;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_cout;
  logic [CW-1:0]    r_cnt;
  logic             w_fs;
  logic             w_fc;
  logic             w_run;
  logic             w_last;
  logic             w_accept;

  full_adder u_fa (
    .a   (r_sha[0]),
    .b   (r_shb[0]),
    .cin (r_carry),
    .sum (w_fs),
    .cout(w_fc)
  );

  assign w_run    = (r_state == S_RUN);
  assign w_last   = w_run &&
                    (r_cnt == CW'(WIDTH - 1));
  assign w_accept = bus.start &&
                    (r_state == S_IDLE ||
                     r_state == S_DONE);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (bus.start) w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_DONE;
      S_DONE:  w_next = bus.start ? S_RUN
                                  : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.busy = 1'b0;
    bus.done = 1'b0;
    unique case (r_state)
      S_RUN:   bus.busy = 1'b1;
      S_DONE:  bus.done = 1'b1;
      default: ;
    endcase
  end

  // sum/cout only change at the RUN->DONE edge
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sha   <= '0;
      r_shb   <= '0;
      r_res   <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_sha   <= bus.a;
      r_shb   <= bus.b;
      r_carry <= bus.cin;
      r_cnt   <= '0;
    end else if (w_run) begin
      r_sha   <= r_sha >> 1;
      r_shb   <= r_shb >> 1;
      r_carry <= w_fc;
      r_res   <= {w_fs, r_res[WIDTH-1:1]};
      r_cnt   <= r_cnt + CW'(1);
      if (w_last) begin
        r_sum  <= {w_fs, r_res[WIDTH-1:1]};
        r_cout <= w_fc;
      end
    end
  end

  assign bus.sum  = r_sum;
  assign bus.cout = r_cout;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed checks for serial_add_ctrl at WIDTH=8.
// Each task drives one scenario and checks inline.
module tb_serial_add_ctrl;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  serial_add_ctrl_if #(.WIDTH(8)) bus_if ();

  serial_add_ctrl #(.WIDTH(8)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Launch one op and wait for done; no checks here.
  task automatic do_add(
    input  logic [7:0] ta,
    input  logic [7:0] tb_,
    input  logic       tc,
    output logic [7:0] s,
    output logic       co,
    output int         lat,
    output int         nbusy,
    output bit         ok
  );
    bus_if.a     = ta;
    bus_if.b     = tb_;
    bus_if.cin   = tc;
    bus_if.start = 1'b1;
    step();
    bus_if.start = 1'b0;
    bus_if.a     = 8'hE7;
    bus_if.b     = 8'h3D;
    lat   = 1;
    nbusy = 0;
    ok    = 0;
    s     = 8'h0;
    co    = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus_if.done) begin
        ok = 1;
        s  = bus_if.sum;
        co = bus_if.cout;
        break;
      end
      if (bus_if.busy) nbusy++;
      step();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    total++;
    if (bus_if.busy !== 1'b0) begin
      bad++;
      $display("FAIL rst_busy got=%b exp=0",
               bus_if.busy);
    end
    total++;
    if (bus_if.done !== 1'b0) begin
      bad++;
      $display("FAIL rst_done got=%b exp=0",
               bus_if.done);
    end
    total++;
    if (bus_if.sum !== 8'h00) begin
      bad++;
      $display("FAIL rst_sum got=%h exp=00",
               bus_if.sum);
    end
    total++;
    if (bus_if.cout !== 1'b0) begin
      bad++;
      $display("FAIL rst_cout got=%b exp=0",
               bus_if.cout);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    logic [7:0] s;
    logic       co;
    int         lat, nb;
    bit         ok;
    do_add(8'h3C, 8'h5A, 1'b0, s, co, lat, nb, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL basic_timeout got=none exp=done");
    end
    total++;
    if (lat !== 9) begin
      bad++;
      $display("FAIL basic_lat got=%0d exp=9", lat);
    end
    total++;
    if (nb !== 8) begin
      bad++;
      $display("FAIL basic_busy got=%0d exp=8", nb);
    end
    total++;
    if (s !== 8'h96 || co !== 1'b0) begin
      bad++;
      $display("FAIL basic_sum got=%b/%h exp=0/96",
               co, s);
    end
    step();
    step();
    step();
    total++;
    if (bus_if.sum !== 8'h96 ||
        bus_if.done !== 1'b0 ||
        bus_if.busy !== 1'b0) begin
      bad++;
      $display("FAIL basic_hold got=%h d%b b%b exp=96 d0 b0",
               bus_if.sum, bus_if.done, bus_if.busy);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] s;
    logic       co;
    int         lat, nb;
    bit         ok;
    do_add(8'hFF, 8'h01, 1'b0, s, co, lat, nb, ok);
    total++;
    if (!ok || s !== 8'h00 || co !== 1'b1) begin
      bad++;
      $display("FAIL wrap1 got=%0d %b/%h exp=1 1/00",
               ok, co, s);
    end
    step();
    do_add(8'hFF, 8'hFF, 1'b1, s, co, lat, nb, ok);
    total++;
    if (!ok || s !== 8'hFF || co !== 1'b1) begin
      bad++;
      $display("FAIL wrap2 got=%0d %b/%h exp=1 1/ff",
               ok, co, s);
    end
    step();
  endtask

  task automatic test_ignore();
    int         nd, nb, kd;
    logic [7:0] s;
    logic       co;
    bus_if.a     = 8'h10;
    bus_if.b     = 8'h20;
    bus_if.cin   = 1'b0;
    bus_if.start = 1'b1;
    step();
    bus_if.start = 1'b0;
    nd = 0;
    nb = 0;
    kd = -1;
    s  = 8'h0;
    co = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      if (k == 3) begin
        bus_if.a     = 8'hAA;
        bus_if.b     = 8'h55;
        bus_if.start = 1'b1;
      end else begin
        bus_if.start = 1'b0;
      end
      if (bus_if.busy && kd < 0) nb++;
      if (bus_if.done) begin
        nd++;
        if (kd < 0) begin
          kd = k;
          s  = bus_if.sum;
          co = bus_if.cout;
        end
      end
      step();
    end
    total++;
    if (nd !== 1) begin
      bad++;
      $display("FAIL ign_ndone got=%0d exp=1", nd);
    end
    total++;
    if (kd !== 9 || nb !== 8) begin
      bad++;
      $display("FAIL ign_timing got=k%0d b%0d exp=k9 b8",
               kd, nb);
    end
    total++;
    if (s !== 8'h30 || co !== 1'b0) begin
      bad++;
      $display("FAIL ign_sum got=%b/%h exp=0/30",
               co, s);
    end
  endtask

  task automatic test_reset_mid();
    int         nd;
    logic [7:0] s;
    logic       co;
    int         lat, nb;
    bit         ok;
    bus_if.a     = 8'h7F;
    bus_if.b     = 8'h01;
    bus_if.cin   = 1'b0;
    bus_if.start = 1'b1;
    step();
    bus_if.start = 1'b0;
    step();
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++;
    if (bus_if.busy !== 1'b0 ||
        bus_if.done !== 1'b0) begin
      bad++;
      $display("FAIL rmid_ctl got=b%b d%b exp=b0 d0",
               bus_if.busy, bus_if.done);
    end
    total++;
    if (bus_if.sum !== 8'h00 ||
        bus_if.cout !== 1'b0) begin
      bad++;
      $display("FAIL rmid_res got=%b/%h exp=0/00",
               bus_if.cout, bus_if.sum);
    end
    nd = 0;
    for (int k = 0; k < 10; k++) begin
      if (bus_if.done) nd++;
      step();
    end
    total++;
    if (nd !== 0) begin
      bad++;
      $display("FAIL rmid_nodone got=%0d exp=0", nd);
    end
    do_add(8'h02, 8'h03, 1'b0, s, co, lat, nb, ok);
    total++;
    if (!ok || lat !== 9 ||
        s !== 8'h05 || co !== 1'b0) begin
      bad++;
      $display("FAIL rmid_fresh got=%0d k%0d %b/%h exp=1 k9 0/05",
               ok, lat, co, s);
    end
    step();
  endtask

  task automatic test_back_to_back();
    int         d1, d2;
    logic [7:0] s1, s2;
    logic       c1, c2;
    logic       b_after;
    d1 = -1;
    d2 = -1;
    s1 = 8'h0;
    s2 = 8'h0;
    c1 = 1'b0;
    c2 = 1'b0;
    b_after = 1'b0;
    bus_if.a     = 8'h01;
    bus_if.b     = 8'h01;
    bus_if.cin   = 1'b0;
    bus_if.start = 1'b1;
    step();
    bus_if.a = 8'h80;
    bus_if.b = 8'h80;
    for (int k = 1; k <= 30; k++) begin
      if (bus_if.done) begin
        if (d1 < 0) begin
          d1 = k;
          s1 = bus_if.sum;
          c1 = bus_if.cout;
        end else if (d2 < 0) begin
          d2 = k;
          s2 = bus_if.sum;
          c2 = bus_if.cout;
        end
      end
      if (d1 >= 0 && k == d1 + 1) begin
        b_after      = bus_if.busy;
        bus_if.start = 1'b0;
      end
      step();
    end
    bus_if.start = 1'b0;
    total++;
    if (d1 !== 9 || d2 - d1 !== 9) begin
      bad++;
      $display("FAIL b2b_gap got=d1 %0d d2 %0d exp=9 18",
               d1, d2);
    end
    total++;
    if (b_after !== 1'b1) begin
      bad++;
      $display("FAIL b2b_bubble got=%b exp=1", b_after);
    end
    total++;
    if (s1 !== 8'h02 || c1 !== 1'b0) begin
      bad++;
      $display("FAIL b2b_r1 got=%b/%h exp=0/02", c1, s1);
    end
    total++;
    if (s2 !== 8'h00 || c2 !== 1'b1) begin
      bad++;
      $display("FAIL b2b_r2 got=%b/%h exp=1/00", c2, s2);
    end
  endtask

  task automatic test_exhaustive();
    logic [7:0] s;
    logic       co;
    int         lat, nb;
    bit         ok;
    logic [8:0] exp9;
    logic [7:0] ta, tb_;
    logic       tc;
    for (int v = 0; v < 8; v++) begin
      ta   = {7'b0, v[2]};
      tb_  = {7'b0, v[1]};
      tc   = v[0];
      exp9 = 9'(ta) + 9'(tb_) + 9'(tc);
      do_add(ta, tb_, tc, s, co, lat, nb, ok);
      total++;
      if (!ok || {co, s} !== exp9) begin
        bad++;
        $display("FAIL exh_%0d got=%0d %b/%h exp=1 %h",
                 v, ok, co, s, exp9);
      end
      step();
    end
  endtask

  initial begin
    total        = 0;
    bad          = 0;
    rst          = 1'b1;
    bus_if.start = 1'b0;
    bus_if.a     = 8'h00;
    bus_if.b     = 8'h00;
    bus_if.cin   = 1'b0;
    #1;
    test_reset();
    test_basic();
    test_wrap();
    test_ignore();
    test_reset_mid();
    test_back_to_back();
    test_exhaustive();
    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end
endmodule
